// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit for the EX stage; owns HI/LO and stalls ID/EX while busy.
// Multiply takes one BUSY cycle, divide is restoring radix-2 with one quotient bit per cycle.
module md_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  EX_in_MDop,
  input  logic [31:0] EX_in_RF_rs_data,
  input  logic [31:0] EX_in_RF_rt_data,
  output logic        EX_stall,
  output logic [31:0] MD_rdata,
  output logic [31:0] MD_hi,
  output logic [31:0] MD_lo
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      r_state, w_state_next;
  logic [5:0]  r_cnt;
  logic [31:0] r_hi, r_lo;
  logic [31:0] r_a, r_b, r_rs;
  logic [63:0] r_rem;
  logic        r_signed, r_is_div, r_neg_q, r_neg_r, r_div0;

  logic        w_start, w_is_div, w_signed;
  logic [31:0] w_rs_op, w_rt_op;
  logic [63:0] w_prod;
  logic [33:0] w_diff;
  logic [63:0] w_rem_next;
  logic [31:0] w_q, w_r;
  logic        w_unused;

  // Lowest set bit of MDop[3:0] selects the op.
  assign w_start  = (r_state == StIdle) & (|EX_in_MDop[3:0]);
  assign w_is_div = ~EX_in_MDop[0] & ~EX_in_MDop[1];
  assign w_signed = EX_in_MDop[0] | (w_is_div & EX_in_MDop[2]);

  // Divide works on magnitudes; multiply keeps the raw operands.
  assign w_rs_op = (w_is_div & w_signed & EX_in_RF_rs_data[31]) ? (32'd0 - EX_in_RF_rs_data)
                                                                 : EX_in_RF_rs_data;
  assign w_rt_op = (w_is_div & w_signed & EX_in_RF_rt_data[31]) ? (32'd0 - EX_in_RF_rt_data)
                                                                 : EX_in_RF_rt_data;

  assign w_prod = {{32{r_signed & r_a[31]}}, r_a} * {{32{r_signed & r_b[31]}}, r_b};

  // Shifted top 33 bits of the partial remainder compared against the divisor.
  assign w_diff     = {1'b0, r_rem[63:31]} - {2'b00, r_b};
  assign w_rem_next = w_diff[33] ? {r_rem[62:0], 1'b0} : {w_diff[31:0], r_rem[30:0], 1'b1};
  assign w_q        = w_rem_next[31:0];
  assign w_r        = w_rem_next[63:32];
  assign w_unused   = w_diff[32];

  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    EX_stall     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_start) begin
          w_state_next = StBusy;
          EX_stall     = 1'b1;
        end
      end
      StBusy: begin
        EX_stall = 1'b1;
        if (r_cnt == 6'd1) w_state_next = StDone;
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
    if (rst) EX_stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= 6'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_rs     <= 32'd0;
      r_rem    <= 64'd0;
      r_signed <= 1'b0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_start) begin
            r_cnt    <= w_is_div ? 6'd32 : 6'd1;
            r_a      <= w_rs_op;
            r_b      <= w_rt_op;
            r_rs     <= EX_in_RF_rs_data;
            r_rem    <= {32'd0, w_rs_op};
            r_signed <= w_signed;
            r_is_div <= w_is_div;
            r_neg_q  <= w_signed & (EX_in_RF_rs_data[31] ^ EX_in_RF_rt_data[31]);
            r_neg_r  <= w_signed & EX_in_RF_rs_data[31];
            r_div0   <= (EX_in_RF_rt_data == 32'd0);
          end else begin
            if (EX_in_MDop[6]) r_hi <= EX_in_RF_rs_data;
            if (EX_in_MDop[7]) r_lo <= EX_in_RF_rs_data;
          end
        end
        StBusy: begin
          r_cnt <= r_cnt - 6'd1;
          if (r_is_div) r_rem <= w_rem_next;
          if (r_cnt == 6'd1) begin
            if (!r_is_div) begin
              r_hi <= w_prod[63:32];
              r_lo <= w_prod[31:0];
            end else if (r_div0) begin
              r_hi <= r_rs;
              r_lo <= 32'hFFFF_FFFF;
            end else begin
              r_hi <= r_neg_r ? (32'd0 - w_r) : w_r;
              r_lo <= r_neg_q ? (32'd0 - w_q) : w_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    MD_rdata = 32'd0;
    if (EX_in_MDop[4])      MD_rdata = r_hi;
    else if (EX_in_MDop[5]) MD_rdata = r_lo;
  end

  assign MD_hi = r_hi;
  assign MD_lo = r_lo;

endmodule
